// File: rtl/bit_serial_adder.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop, LSB first.
// Operands are captured on start; the result, carry and signed overflow are registered at completion.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Returns {carry, sum} of a single-bit full adder.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  state_t           state_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-1:0] res_sh_r;
  logic             carry_r;
  logic [CNT_W-1:0] cnt_r;

  logic [1:0]       fa_s;
  logic [WIDTH-1:0] res_next_s;
  logic             last_bit_s;

  // Full-adder cell and the next value of the result shift register.
  always_comb begin
    fa_s       = full_add(a_sh_r[0], b_sh_r[0], carry_r);
    res_next_s = {fa_s[0], res_sh_r[WIDTH-1:1]};
    last_bit_s = (cnt_r == LAST_BIT);
  end

  // Control FSM with datapath shift registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      a_sh_r    <= '0;
      b_sh_r    <= '0;
      res_sh_r  <= '0;
      carry_r   <= 1'b0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            // Subtraction is a + ~b + 1: invert B and seed the carry with 1.
            a_sh_r  <= a;
            b_sh_r  <= mode ? ~b : b;
            carry_r <= mode ? 1'b1 : carry_in;
            cnt_r   <= '0;
            busy    <= 1'b1;
            state_r <= ST_RUN;
          end else begin
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_RUN: begin
          a_sh_r   <= a_sh_r >> 1;
          b_sh_r   <= b_sh_r >> 1;
          res_sh_r <= res_next_s;
          carry_r  <= fa_s[1];
          cnt_r    <= cnt_r + CNT_W'(1);
          if (last_bit_s) begin
            // At the MSB, carry_r still holds the carry into the MSB.
            sum       <= res_next_s;
            carry_out <= fa_s[1];
            overflow  <= carry_r ^ fa_s[1];
            busy      <= 1'b0;
            done      <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            done    <= 1'b0;
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bit_serial_adder.sv
// Self-checking bench: directed and random ops on an 8-bit instance, exhaustive on a 4-bit one,
// checked against an integer-arithmetic reference model.
module tb_bit_serial_adder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic       start8 = 1'b0, mode8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       busy8, done8, co8, ov8;
  logic [7:0] sum8;

  logic       start4 = 1'b0, mode4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       busy4, done4, co4, ov4;
  logic [3:0] sum4;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] prev_sum8 = '0;
  logic       prev_co8  = 1'b0;
  logic       prev_ov8  = 1'b0;

  always #5 clk = ~clk;

  bit_serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .mode(mode8), .a(a8), .b(b8), .carry_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry_out(co8), .overflow(ov8)
  );

  bit_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .mode(mode4), .a(a4), .b(b4), .carry_in(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .carry_out(co4), .overflow(ov4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, unsigned for sum/carry, signed range for overflow.
  function automatic void model(input int w, input int ua, input int ub, input bit m, input bit ci,
                                output int s, output bit co, output bit ov);
    int md, half, sa, sb, ss, us;
    md   = 1 << w;
    half = 1 << (w - 1);
    sa   = (ua >= half) ? ua - md : ua;
    sb   = (ub >= half) ? ub - md : ub;
    if (m) begin
      us = ua - ub;
      co = (ua >= ub);
      ss = sa - sb;
    end else begin
      us = ua + ub + int'(ci);
      co = (us >= md);
      ss = sa + sb + int'(ci);
    end
    s  = ((us % md) + md) % md;
    ov = (ss >= half) || (ss < -half);
  endfunction

  task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tm, input logic tc,
                     input bit junk);
    int es; bit ec, eo;
    model(8, int'(ta), int'(tb), tm, tc, es, ec, eo);
    start8 = 1'b1; a8 = ta; b8 = tb; mode8 = tm; cin8 = tc;
    @(posedge clk); #1;
    check("e0_busy", busy8, 1); check("e0_done", done8, 0); check("e0_sum_hold", sum8, prev_sum8);
    for (int k = 1; k <= 8; k++) begin
      start8 = junk;
      a8     = junk ? 8'hAA : 8'($urandom);
      b8     = 8'($urandom);
      mode8  = 1'($urandom);
      cin8   = 1'($urandom);
      @(posedge clk); #1;
      if (k < 8) begin
        check("run_busy", busy8, 1);
        check("run_done", done8, 0);
        check("run_sum_hold", sum8, prev_sum8);
        check("run_co_hold", co8, prev_co8);
        check("run_ov_hold", ov8, prev_ov8);
      end
    end
    check("fin_busy", busy8, 0); check("fin_done", done8, 1);
    check("fin_sum", sum8, es); check("fin_co", co8, ec); check("fin_ov", ov8, eo);
    prev_sum8 = 8'(es); prev_co8 = ec; prev_ov8 = eo;
    @(posedge clk); #1;
    check("post_done", done8, 0); check("post_busy", busy8, 0); check("post_sum", sum8, es);
    start8 = 1'b0;
  endtask

  task automatic op4(input logic [3:0] ta, input logic [3:0] tb, input logic tm, input logic tc);
    int es; bit ec, eo;
    model(4, int'(ta), int'(tb), tm, tc, es, ec, eo);
    start4 = 1'b1; a4 = ta; b4 = tb; mode4 = tm; cin4 = tc;
    @(posedge clk); #1;
    start4 = 1'b0;
    check("w4_e0_busy", busy4, 1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      check("w4_done_timing", done4, (k == 4) ? 1 : 0);
    end
    check("w4_sum", sum4, es); check("w4_co", co4, ec); check("w4_ov", ov4, eo);
    @(posedge clk); #1;
    check("w4_post_done", done4, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy8, 0); check("rst_done", done8, 0); check("rst_sum", sum8, 0);
    check("rst_co", co8, 0); check("rst_ov", ov8, 0); check("rst_sum4", sum4, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed arithmetic cases, including a sub with carry_in high.
    op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
    op8(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
    op8(8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
    op8(8'h80, 8'h01, 1'b1, 1'b1, 1'b0);
    op8(8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    op8(8'h7F, 8'h80, 1'b1, 1'b0, 1'b0);

    // Start pulses with new operands while busy and in DONE are ignored.
    op8(8'h01, 8'h01, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 40; i++)
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));

    // Reset in the middle of an add aborts it.
    start8 = 1'b1; a8 = 8'h40; b8 = 8'h05; mode8 = 1'b0; cin8 = 1'b0;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("arst_busy", busy8, 0); check("arst_done", done8, 0); check("arst_sum", sum8, 0);
    check("arst_co", co8, 0); check("arst_ov", ov8, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    prev_sum8 = '0; prev_co8 = 1'b0; prev_ov8 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("arst_no_done", done8, 0);
      check("arst_idle", busy8, 0);
    end
    op8(8'h22, 8'h11, 1'b0, 1'b0, 1'b0);

    // Exhaustive 4-bit sweep.
    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int im = 0; im < 2; im++)
          for (int ic = 0; ic < 2; ic++)
            op4(4'(ia), 4'(ib), 1'(im), 1'(ic));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
